// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX path: beat layout, write FSM states and a
// saturating counter helper used by the optional statistics (ETH_TX_FRAME_STATS_EN).
package eth_pkg;

  localparam int ETH_DATA_W = 64;
  localparam int ETH_KEEP_W = 8;

  // Field order gives the stored word layout {tlast, tkeep, tdata}.
  typedef struct packed {
    logic                  last;
    logic [ETH_KEEP_W-1:0] keep;
    logic [ETH_DATA_W-1:0] data;
  } eth_beat_t;

  localparam int ETH_BEAT_W = $bits(eth_beat_t);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WRITE,
    WR_DROP
  } wr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ethernet_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module ethernet_sdp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 73
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ethernet_tx_frame_buffer.sv
// Store-and-forward TX frame buffer: frames become visible to the MAC only once
// their tlast beat is stored; frames that overflow are dropped whole.
// Optional frame statistics: define ETH_TX_FRAME_STATS_EN.
module ethernet_tx_frame_buffer
  import eth_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_s_axis_tvalid,
  input  logic [ETH_DATA_W-1:0] i_s_axis_tdata,
  input  logic                  i_s_axis_tlast,
  input  logic [ETH_KEEP_W-1:0] i_s_axis_tkeep,
  output logic                  o_m_axis_tvalid,
  output logic [ETH_DATA_W-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tlast,
  output logic [ETH_KEEP_W-1:0] o_m_axis_tkeep,
  input  logic                  i_m_axis_tready,
  output logic                  o_drop,
  output logic [15:0]           o_tx_frames,
  output logic [15:0]           o_drop_frames
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  wr_state_t       wr_state_reg;
  logic [ADDR_W:0] wr_tmp_reg;
  logic [ADDR_W:0] wr_commit_reg;
  logic [ADDR_W:0] rd_ptr_reg;
  logic            drop_reg;

  logic            full;
  logic            wr_en;
  eth_beat_t       in_beat;

  logic            avail;
  logic            out_ready;
  logic            rd_issue;
  logic            ram_valid_reg;
  eth_beat_t       ram_rd_data;
  logic            out_valid_reg;
  eth_beat_t       out_beat_reg;

  assign in_beat = '{last: i_s_axis_tlast, keep: i_s_axis_tkeep, data: i_s_axis_tdata};

  // Fullness uses the registered read pointer, so a same-cycle read only helps next cycle.
  assign full  = (wr_tmp_reg - rd_ptr_reg) == DEPTH;
  assign wr_en = i_s_axis_tvalid && !full && (wr_state_reg != WR_DROP);

  ethernet_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (ETH_BEAT_W)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_tmp_reg[ADDR_W-1:0]),
    .wr_data (in_beat),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  // Write side: wr_tmp runs ahead of wr_commit while a frame is being stored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_state_reg  <= WR_IDLE;
      wr_tmp_reg    <= '0;
      wr_commit_reg <= '0;
      drop_reg      <= 1'b0;
    end else begin
      drop_reg <= 1'b0;
      case (wr_state_reg)
        WR_IDLE, WR_WRITE: begin
          if (i_s_axis_tvalid) begin
            if (!full) begin
              wr_tmp_reg <= wr_tmp_reg + 1'b1;
              if (i_s_axis_tlast) begin
                wr_commit_reg <= wr_tmp_reg + 1'b1;
                wr_state_reg  <= WR_IDLE;
              end else begin
                wr_state_reg  <= WR_WRITE;
              end
            end else begin
              // Overflow: forget the partial frame and discard the rest of it.
              wr_tmp_reg <= wr_commit_reg;
              if (i_s_axis_tlast) begin
                drop_reg     <= 1'b1;
                wr_state_reg <= WR_IDLE;
              end else begin
                wr_state_reg <= WR_DROP;
              end
            end
          end
        end
        WR_DROP: begin
          if (i_s_axis_tvalid && i_s_axis_tlast) begin
            drop_reg     <= 1'b1;
            wr_state_reg <= WR_IDLE;
          end
        end
        default: wr_state_reg <= WR_IDLE;
      endcase
    end
  end

  // Read side: RAM output register feeds the output register; a new read is
  // issued whenever the RAM stage is empty or is moving forward this cycle.
  assign avail     = rd_ptr_reg != wr_commit_reg;
  assign out_ready = !out_valid_reg || i_m_axis_tready;
  assign rd_issue  = avail && (!ram_valid_reg || out_ready);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr_reg    <= '0;
      ram_valid_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_beat_reg  <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        ram_valid_reg <= 1'b1;
      end else if (out_ready) begin
        ram_valid_reg <= 1'b0;
      end
      if (out_ready) begin
        out_valid_reg <= ram_valid_reg;
        if (ram_valid_reg) begin
          out_beat_reg <= ram_rd_data;
        end
      end
    end
  end

  assign o_m_axis_tvalid = out_valid_reg;
  assign o_m_axis_tdata  = out_beat_reg.data;
  assign o_m_axis_tkeep  = out_beat_reg.keep;
  assign o_m_axis_tlast  = out_beat_reg.last;
  assign o_drop          = drop_reg;

`ifdef ETH_TX_FRAME_STATS_EN
  // Index 0 counts sent frames, index 1 counts dropped frames.
  logic [1:0] stat_inc;
  assign stat_inc = {drop_reg, out_valid_reg && i_m_axis_tready && out_beat_reg.last};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi]) begin
        cnt_reg <= sat_inc16(cnt_reg);
      end
    end
  end

  assign o_tx_frames   = g_stat[0].cnt_reg;
  assign o_drop_frames = g_stat[1].cnt_reg;
`else
  assign o_tx_frames   = '0;
  assign o_drop_frames = '0;
`endif

endmodule

// File: tb/tb_ethernet_tx_frame_buffer.sv
// Directed bench: a 256-word and a 16-word buffer share one stimulus stream so
// the overflow cases can be seen against a buffer large enough to keep everything.
module tb_ethernet_tx_frame_buffer;

`ifdef ETH_TX_FRAME_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef logic [72:0] beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic [63:0] s_tdata;
  logic        s_tlast;
  logic [7:0]  s_tkeep;
  logic        m_tready;

  logic        a_tvalid, a_tlast, a_drop;
  logic [63:0] a_tdata;
  logic [7:0]  a_tkeep;
  logic [15:0] a_tx, a_dropf;
  logic        b_tvalid, b_tlast, b_drop;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;
  logic [15:0] b_tx, b_dropf;

  always #5 clk = ~clk;

  ethernet_tx_frame_buffer #(.ADDR_W(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_s_axis_tvalid(s_tvalid), .i_s_axis_tdata(s_tdata),
    .i_s_axis_tlast(s_tlast), .i_s_axis_tkeep(s_tkeep),
    .o_m_axis_tvalid(a_tvalid), .o_m_axis_tdata(a_tdata),
    .o_m_axis_tlast(a_tlast), .o_m_axis_tkeep(a_tkeep),
    .i_m_axis_tready(m_tready), .o_drop(a_drop),
    .o_tx_frames(a_tx), .o_drop_frames(a_dropf)
  );

  ethernet_tx_frame_buffer #(.ADDR_W(4)) dut_small (
    .i_clk(clk), .i_reset(rst),
    .i_s_axis_tvalid(s_tvalid), .i_s_axis_tdata(s_tdata),
    .i_s_axis_tlast(s_tlast), .i_s_axis_tkeep(s_tkeep),
    .o_m_axis_tvalid(b_tvalid), .o_m_axis_tdata(b_tdata),
    .o_m_axis_tlast(b_tlast), .o_m_axis_tkeep(b_tkeep),
    .i_m_axis_tready(m_tready), .o_drop(b_drop),
    .o_tx_frames(b_tx), .o_drop_frames(b_dropf)
  );

  beat_t a_q[$], b_q[$], exp_a[$], exp_b[$];
  int    a_cyc[$];
  int    cyc = 0;
  int    a_drop_cnt = 0, b_drop_cnt = 0, b_drop_cyc = -1;
  int    n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled mid-cycle, records each accepted beat and drop pulse.
  always @(negedge clk) begin
    if (a_tvalid && m_tready) begin
      a_q.push_back({a_tlast, a_tkeep, a_tdata});
      a_cyc.push_back(cyc);
    end
    if (b_tvalid && m_tready) b_q.push_back({b_tlast, b_tkeep, b_tdata});
    if (a_drop) a_drop_cnt++;
    if (b_drop) begin
      b_drop_cnt++;
      b_drop_cyc = cyc;
    end
  end

  task automatic check_value(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives one frame back-to-back; expected beats go to the queues of the
  // buffers that must keep it. last_edge = cycle count after the tlast edge.
  task automatic send_frame(input int id, input int nbeats, input logic [7:0] last_keep,
                            input bit to_a, input bit to_b, output int last_edge);
    for (int i = 0; i < nbeats; i++) begin
      beat_t bt;
      @(posedge clk); #1;
      bt = {(i == nbeats - 1), (i == nbeats - 1) ? last_keep : 8'hFF,
            {8'(id), 8'(i), 48'hA5A5_0F0F_3C3C}};
      s_tvalid = 1'b1;
      s_tlast  = bt[72];
      s_tkeep  = bt[71:64];
      s_tdata  = bt[63:0];
      if (to_a) exp_a.push_back(bt);
      if (to_b) exp_b.push_back(bt);
      last_edge = cyc + 1;
    end
    $display("frame %0d: %0d beats sent, kept by big=%0d small=%0d", id, nbeats, to_a, to_b);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_frames(input string name);
    check_value({name, " big count"}, a_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < a_q.size(); i++)
      check_value($sformatf("%s big beat %0d", name, i), a_q[i], exp_a[i]);
    check_value({name, " small count"}, b_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < b_q.size(); i++)
      check_value($sformatf("%s small beat %0d", name, i), b_q[i], exp_b[i]);
    a_q.delete(); b_q.delete(); exp_a.delete(); exp_b.delete(); a_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int le, da0, db0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tkeep = '0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset big out", {a_tvalid, a_tlast, a_tkeep, a_tdata}, '0);
    check_value("reset big misc", {a_drop, a_tx, a_dropf}, '0);
    check_value("reset small out", {b_tvalid, b_tlast, b_tkeep, b_tdata}, '0);
    check_value("reset small misc", {b_drop, b_tx, b_dropf}, '0);
    rst = 1'b0;
    m_tready = 1'b1;

    // T1: single 8-beat frame, latency of two edges after tlast
    send_frame(1, 8, 8'h0F, 1, 1, le);
    idle(20);
    check_value("T1 latency", (a_cyc.size() > 0) ? a_cyc[0] - le : -1, 2);
    check_value("T1 tx_frames big", a_tx, STATS * 1);
    check_value("T1 tx_frames small", b_tx, STATS * 1);
    compare_frames("T1");

    // T2: three back-to-back frames must stream without bubbles
    send_frame(2, 4, 8'h3F, 1, 1, le);
    send_frame(3, 4, 8'h01, 1, 1, le);
    send_frame(4, 4, 8'hFF, 1, 1, le);
    idle(20);
    check_value("T2 contiguous", (a_cyc.size() == 12) ? a_cyc[11] - a_cyc[0] : 0, 11);
    compare_frames("T2");

    // T3: tready toggling every cycle
    fork
      begin
        send_frame(5, 6, 8'h07, 1, 1, le);
        idle(30);
      end
      begin
        repeat (30) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    compare_frames("T3");

    // T4: tready low, two 10-beat frames; the small buffer must drop the second
    m_tready = 1'b0;
    da0 = a_drop_cnt;
    db0 = b_drop_cnt;
    send_frame(6, 10, 8'hFF, 1, 1, le);
    send_frame(7, 10, 8'h03, 1, 0, le);
    idle(5);
    check_value("T4 small drop pulses", b_drop_cnt - db0, 1);
    check_value("T4 small drop cycle", b_drop_cyc, le);
    check_value("T4 big drop pulses", a_drop_cnt - da0, 0);
    check_value("T4 small drop_frames", b_dropf, STATS * 1);
    m_tready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    compare_frames("T4");

    // T5: frame longer than the small buffer is always dropped
    db0 = b_drop_cnt;
    send_frame(8, 20, 8'h1F, 1, 0, le);
    idle(40);
    check_value("T5 small drop pulses", b_drop_cnt - db0, 1);
    compare_frames("T5");
    check_value("T5 tx_frames big", a_tx, STATS * 8);
    check_value("T5 tx_frames small", b_tx, STATS * 6);
    check_value("T5 drop_frames big", a_dropf, 0);
    check_value("T5 drop_frames small", b_dropf, STATS * 2);

    // T6: reset in the middle of a frame, then a fresh 2-beat frame
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tlast  = 1'b0;
      s_tkeep  = 8'hFF;
      s_tdata  = {8'hEE, 8'(i), 48'h0};
    end
    @(posedge clk); #1;
    rst = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("T6 reset big", {a_tvalid, a_drop, a_tx, a_dropf}, '0);
    check_value("T6 reset small", {b_tvalid, b_drop, b_tx, b_dropf}, '0);
    rst = 1'b0;
    send_frame(9, 2, 8'h0F, 1, 1, le);
    idle(20);
    compare_frames("T6");
    check_value("T6 tx_frames big", a_tx, STATS * 1);
    check_value("T6 tx_frames small", b_tx, STATS * 1);
    check_value("T6 drop_frames small", b_dropf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
